// File: rtl/data_memory_responder.sv
// data_memory_responder: load/store target with fixed wait-state latency, byte/half lanes and fault reporting.
module data_memory_responder #(
    parameter int    MEMORY_DEPTH = 1024,
    parameter int    WAIT_STATES  = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        access_fault
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [31:0]   mem [MEMORY_DEPTH];
    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, wd_q, rdata_q;
    logic [2:0]    f3_q;
    logic          wr_q, both_q, ready_q, fault_q;
    logic          idle, req, commit, wr, both, fault;
    logic [31:0]   a, wd, word, wsh, merged, ld;
    logic [2:0]    f3;
    logic [3:0]    be;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [7:0]    lb;
    logic [15:0]   lh;

    assign idle   = state_q == IDLE;
    assign req    = memory_read | memory_write;
    assign commit = state_d == DONE;
    assign a      = idle ? address : addr_q;
    assign wd     = idle ? write_data : wd_q;
    assign f3     = idle ? funct3 : f3_q;
    assign wr     = idle ? memory_write : wr_q;
    assign both   = idle ? memory_read & memory_write : both_q;
    assign lane   = a[1:0];
    assign idx    = a[AW+1:2];
    assign word   = mem[idx];
    assign lb     = word[{lane, 3'b000} +: 8];
    assign lh     = word[{lane[1], 4'b0000} +: 16];
    assign wsh    = wd << {lane, 3'b000};

    always_comb begin
        state_d = idle ? (req ? (WAIT_STATES == 0 ? DONE : WAIT) : IDLE)
                : state_q == WAIT ? (cnt_q == 4'd1 ? DONE : WAIT) : IDLE;
        cnt_d   = idle ? (req ? WS : cnt_q) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
        ld      = f3 == 3'b000 ? {{24{lb[7]}}, lb} : f3 == 3'b100 ? {24'b0, lb}
                : f3 == 3'b001 ? {{16{lh[15]}}, lh} : f3 == 3'b101 ? {16'b0, lh} : word;
        fault   = both | (|a[31:AW+2]) | (f3[1:0] == 2'b11) | (f3[2] & (wr | f3[1]))
                | (f3[0] & a[0]) | (f3[1] & (|a[1:0]));
        be      = f3[1:0] == 2'b00 ? 4'b0001 << lane : f3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        merged  = word;
        for (int k = 0; k < 4; k++) merged[8*k +: 8] = be[k] ? wsh[8*k +: 8] : word[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= commit;
            fault_q <= commit & fault;
            rdata_q <= (commit & ~fault & ~wr) ? ld : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (idle) begin
            addr_q <= address;
            wd_q   <= write_data;
            f3_q   <= funct3;
            wr_q   <= memory_write;
            both_q <= memory_read & memory_write;
        end
        if (!reset && commit && wr && !fault) mem[idx] <= merged;
    end

    assign read_data    = rdata_q;
    assign ready        = ready_q;
    assign access_fault = fault_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized loads/stores against a word-array reference model.
module tb_data_memory_responder;
    localparam int DEPTH = 256;

    logic clk = 0, reset = 1;
    logic mr = 0, mw = 0, r3 = 0, r0 = 0;
    logic [31:0] addr = 0, wd = 0, rd, rd3, rd0;
    logic [2:0] f3 = 0;
    logic rdy, flt, rdy3, flt3, rdy0, flt0;
    always #5 clk = ~clk;

    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .memory_read(mr), .memory_write(mw), .address(addr),
        .write_data(wd), .funct3(f3), .read_data(rd), .ready(rdy), .access_fault(flt));
    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .memory_read(r3), .memory_write(1'b0), .address(32'h0),
        .write_data(32'h0), .funct3(3'b010), .read_data(rd3), .ready(rdy3), .access_fault(flt3));
    data_memory_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .memory_read(r0), .memory_write(1'b0), .address(32'h0),
        .write_data(32'h0), .funct3(3'b010), .read_data(rd0), .ready(rdy0), .access_fault(flt0));

    int cyc = 0, exp_cyc = -1, n_chk = 0, n_fail = 0;
    bit exp_f, exp_dchk;
    logic [31:0] exp_d;
    logic [31:0] mm [DEPTH];
    logic [2:0] ft [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int size_of(logic [2:0] f);
        return f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic bit mfault(bit r, bit w, logic [31:0] a, logic [2:0] f);
        bit legal = w ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return (r && w) || !legal || (a % size_of(f) != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] mload(logic [31:0] a, logic [2:0] f);
        logic [31:0] w = mm[a / 4];
        logic [31:0] v = w >> (8 * (a % 4));
        case (f)
            3'd0: begin v &= 32'hFF; if (v >= 128) v |= 32'hFFFFFF00; end
            3'd4: v &= 32'hFF;
            3'd1: begin v &= 32'hFFFF; if (v >= 32768) v |= 32'hFFFF0000; end
            3'd5: v &= 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic void mstore(logic [31:0] a, logic [31:0] d, logic [2:0] f);
        logic [31:0] w = mm[a / 4];
        for (int i = 0; i < size_of(f); i++) w[8 * (int'(a % 4) + i) +: 8] = d[8*i +: 8];
        mm[a / 4] = w;
    endfunction

    always @(negedge clk) if (cyc > 0) begin
        chk("ready", 32'(rdy), 32'(cyc == exp_cyc));
        if (rdy && cyc == exp_cyc) begin
            chk("access_fault", 32'(flt), 32'(exp_f));
            if (exp_dchk) chk("read_data", rd, exp_d);
        end else begin
            chk("fault_idle", 32'(flt), 0);
            chk("data_idle", rd, 0);
        end
    end

    task automatic req(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] f,
                       bit lit_en = 0, logic [31:0] lit = 0);
        int k;
        @(negedge clk);
        mr = r; mw = w; addr = a; wd = d; f3 = f;
        exp_f = mfault(r, w, a, f);
        exp_dchk = exp_f || !w;
        exp_d = exp_f ? 32'd0 : mload(a, f);
        if (!exp_f && w) mstore(a, d, f);
        exp_cyc = cyc + 2;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy) break;
        end
        if (!rdy) chk("ready_timeout", 0, 1);
        else if (lit_en) chk("literal", rd, lit);
        mr = 0; mw = 0;
    endtask

    task automatic burst(int ws);
        bit e;
        @(negedge clk);
        if (ws == 3) r3 = 1; else r0 = 1;
        for (int i = 1; i <= 3 * (ws + 2) + 1; i++) begin
            @(negedge clk);
            e = (i >= ws + 1) && ((i - ws - 1) % (ws + 2) == 0);
            chk($sformatf("burst_ready_ws%0d", ws), 32'(ws == 3 ? rdy3 : rdy0), 32'(e));
            chk($sformatf("burst_fault_ws%0d", ws), 32'(ws == 3 ? flt3 : flt0), 0);
        end
        r3 = 0; r0 = 0;
        repeat (ws + 4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        repeat (3) @(negedge clk);
        reset = 0;
        for (int i = 0; i < DEPTH; i++) req(0, 1, 32'(i * 4), $urandom, 3'd2);
        req(0, 1, 32'h10, 32'hDEADBEEF, 3'd2);
        req(1, 0, 32'h10, 0, 3'd2, 1, 32'hDEADBEEF);
        req(0, 1, 32'h10, 32'h11223344, 3'd2);
        req(0, 1, 32'h13, 32'h00000080, 3'd0);
        req(1, 0, 32'h10, 0, 3'd2, 1, 32'h80223344);
        req(1, 0, 32'h13, 0, 3'd0, 1, 32'hFFFFFF80);
        req(1, 0, 32'h13, 0, 3'd4, 1, 32'h00000080);
        req(1, 0, 32'h12, 0, 3'd1, 1, 32'hFFFF8022);
        req(1, 0, 32'h02, 0, 3'd2, 1, 32'h0);
        req(0, 1, 32'h01, 32'hFFFF, 3'd1, 1, 32'h0);
        req(1, 0, 32'(DEPTH * 4), 0, 3'd2, 1, 32'h0);
        req(1, 0, 32'h0, 0, 3'd2);
        req(0, 1, 32'((DEPTH - 1) * 4), 32'hA5A50001, 3'd2);
        req(1, 0, 32'((DEPTH - 1) * 4), 0, 3'd2, 1, 32'hA5A50001);
        req(1, 0, 32'h0, 0, 3'd2);
        req(1, 1, 32'h0, 32'h12345678, 3'd2, 1, 32'h0);
        req(1, 0, 32'h0, 0, 3'd2);
        @(negedge clk);
        mw = 1; addr = 32'h20; wd = 32'hCAFEF00D; f3 = 3'd2;
        @(negedge clk);
        reset = 1; mw = 0; exp_cyc = -1;
        @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);
        req(1, 0, 32'h20, 0, 3'd2);
        burst(3);
        burst(0);
        for (int n = 0; n < 300; n++) begin
            int s = $urandom_range(19, 0);
            a = ($urandom_range(DEPTH + 2, 0) << 2) | $urandom_range(3, 0);
            if ($urandom_range(15, 0) == 0) a |= 32'h80000000;
            req(s < 9 || s == 18, s >= 9, a, $urandom, ft[$urandom_range(9, 0)]);
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
